// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MEM/WB write-back stage: result select/extend, GPR file, bypass reads, retire trace
module wb_regfile #(
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      mem_pc,
  input  logic [31:0]      mem_alu_out,
  input  logic [31:0]      mem_ram_out,
  input  logic [31:0]      mem_rdata1,
  input  logic [2:0]       mem_rf_wsel,
  input  logic             mem_rf_nwe,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       raddr1,
  input  logic [4:0]       raddr2,
  output logic [31:0]      rdata1,
  output logic [31:0]      rdata2,
  output logic             wb_we,
  output logic [4:0]       wb_waddr,
  output logic [31:0]      wb_wdata,
  output logic [31:0]      wb_pc,
  output logic [CNT_W-1:0] wb_count
);

  localparam logic [2:0] SEL_ALU  = 3'd0;
  localparam logic [2:0] SEL_RAM  = 3'd1;
  localparam logic [2:0] SEL_LINK = 3'd2;
  localparam logic [2:0] SEL_RS   = 3'd3;
  localparam logic [2:0] SEL_LB   = 3'd4;
  localparam logic [2:0] SEL_LBU  = 3'd5;
  localparam logic [2:0] SEL_LH   = 3'd6;
  localparam logic [2:0] SEL_LHU  = 3'd7;

  logic [31:0]      r_gpr [NREG];
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_wdata;
  logic             w_fire;
  logic [31:0]      w_rd1;
  logic [31:0]      w_rd2;

  // A write only fires outside reset, when enabled (active-low) and not aimed at r0.
  assign w_fire = !reset && !mem_rf_nwe && (mem_rd != 5'd0);

  // Little-endian lane extraction from the aligned RAM word; alu_out[0] is ignored for halves.
  always_comb begin
    w_byte = mem_ram_out[7:0];
    case (mem_alu_out[1:0])
      2'd0:    w_byte = mem_ram_out[7:0];
      2'd1:    w_byte = mem_ram_out[15:8];
      2'd2:    w_byte = mem_ram_out[23:16];
      default: w_byte = mem_ram_out[31:24];
    endcase
    w_half = mem_alu_out[1] ? mem_ram_out[31:16] : mem_ram_out[15:0];
  end

  // Write-data select with sign/zero extension for sub-word loads.
  always_comb begin
    w_wdata = mem_alu_out;
    case (mem_rf_wsel)
      SEL_ALU:  w_wdata = mem_alu_out;
      SEL_RAM:  w_wdata = mem_ram_out;
      SEL_LINK: w_wdata = mem_pc + 32'd4;
      SEL_RS:   w_wdata = mem_rdata1;
      SEL_LB:   w_wdata = {{24{w_byte[7]}}, w_byte};
      SEL_LBU:  w_wdata = {24'd0, w_byte};
      SEL_LH:   w_wdata = {{16{w_half[15]}}, w_half};
      SEL_LHU:  w_wdata = {16'd0, w_half};
      default:  w_wdata = mem_alu_out;
    endcase
  end

  // GPR array: cleared on reset, otherwise commits the fired write on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_gpr[i] <= '0;
      end
    end else if (w_fire) begin
      r_gpr[mem_rd] <= w_wdata;
    end
  end

  // Read ports: r0 and reset force zero, a same-cycle write to the address is forwarded.
  always_comb begin
    w_rd1 = r_gpr[raddr1];
    w_rd2 = r_gpr[raddr2];
    if (reset || raddr1 == 5'd0) begin
      w_rd1 = '0;
    end else if (w_fire && mem_rd == raddr1) begin
      w_rd1 = w_wdata;
    end
    if (reset || raddr2 == 5'd0) begin
      w_rd2 = '0;
    end else if (w_fire && mem_rd == raddr2) begin
      w_rd2 = w_wdata;
    end
  end

  assign rdata1 = w_rd1;
  assign rdata2 = w_rd2;

  // Retire trace: strobe every cycle, payload only captured when a write fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_we    <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
      wb_pc    <= '0;
    end else begin
      wb_we <= w_fire;
      if (w_fire) begin
        wb_waddr <= mem_rd;
        wb_wdata <= w_wdata;
        wb_pc    <= mem_pc;
      end
    end
  end

  // Retire counter, free-running modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_count <= '0;
    end else if (w_fire) begin
      wb_count <= wb_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile
module tb_wb_regfile;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      mem_pc, mem_alu_out, mem_ram_out, mem_rdata1;
  logic [2:0]       mem_rf_wsel;
  logic             mem_rf_nwe;
  logic [4:0]       mem_rd, raddr1, raddr2;
  logic [31:0]      rdata1, rdata2;
  logic             wb_we;
  logic [4:0]       wb_waddr;
  logic [31:0]      wb_wdata, wb_pc;
  logic [CNT_W-1:0] wb_count;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_count = '0;

  wb_regfile #(.NREG(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .mem_pc(mem_pc), .mem_alu_out(mem_alu_out), .mem_ram_out(mem_ram_out),
    .mem_rdata1(mem_rdata1), .mem_rf_wsel(mem_rf_wsel), .mem_rf_nwe(mem_rf_nwe),
    .mem_rd(mem_rd), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_pc(wb_pc),
    .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fire one write, check the bypass path, then the array copy and the trace next cycle.
  task automatic do_write(input string tag, input logic [4:0] rd, input logic [2:0] wsel,
                          input logic [31:0] alu, input logic [31:0] pc,
                          input logic [31:0] exp);
    mem_rf_nwe  = 1'b0;
    mem_rd      = rd;
    mem_rf_wsel = wsel;
    mem_alu_out = alu;
    mem_pc      = pc;
    raddr1      = rd;
    #1;
    chk({tag, "_bypass"}, rdata1, exp);
    tick();
    mem_rf_nwe = 1'b1;
    exp_count  = exp_count + 1'b1;
    #1;
    chk({tag, "_array"}, rdata1, exp);
    chk({tag, "_we"}, {31'd0, wb_we}, 32'd1);
    chk({tag, "_waddr"}, {27'd0, wb_waddr}, {27'd0, rd});
    chk({tag, "_wdata"}, wb_wdata, exp);
    chk({tag, "_pc"}, wb_pc, pc);
    chk({tag, "_count"}, {24'd0, wb_count}, {24'd0, exp_count});
  endtask

  initial begin
    reset = 1'b1; mem_pc = '0; mem_alu_out = '0; mem_ram_out = '0; mem_rdata1 = '0;
    mem_rf_wsel = '0; mem_rf_nwe = 1'b1; mem_rd = '0; raddr1 = '0; raddr2 = '0;
    tick();
    reset = 1'b0;
    #1;
    // 1: reset state
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1;
      chk($sformatf("reset_r%0d_p1", i), rdata1, 32'd0);
      chk($sformatf("reset_r%0d_p2", 31 - i), rdata2, 32'd0);
    end
    chk("reset_count", {24'd0, wb_count}, 32'd0);
    chk("reset_we", {31'd0, wb_we}, 32'd0);

    // 2: basic write with dual-port bypass
    raddr2 = 5'd5;
    do_write("alu_r5", 5'd5, 3'd0, 32'hDEADBEEF, 32'h0000_0100, 32'hDEADBEEF);
    chk("r5_port2", rdata2, 32'hDEADBEEF);

    // 3: load extraction
    mem_ram_out = 32'h80FF7F01;
    do_write("lb_l3",  5'd10, 3'd4, 32'h0000_0003, 32'h0000_0104, 32'hFFFFFF80);
    do_write("lbu_l1", 5'd11, 3'd5, 32'h0000_0001, 32'h0000_0108, 32'h0000007F);
    do_write("lh_h1",  5'd12, 3'd6, 32'h0000_0002, 32'h0000_010C, 32'hFFFF80FF);
    do_write("lhu_a3", 5'd13, 3'd7, 32'h0000_0003, 32'h0000_0110, 32'h000080FF);
    do_write("lb_l0",  5'd16, 3'd4, 32'h0000_0000, 32'h0000_0114, 32'h00000001);
    do_write("lh_h0",  5'd17, 3'd6, 32'h0000_0000, 32'h0000_0118, 32'h00007F01);
    do_write("ram",    5'd14, 3'd1, 32'h0000_0000, 32'h0000_011C, 32'h80FF7F01);
    mem_rdata1 = 32'h13579BDF;
    do_write("rs",     5'd15, 3'd3, 32'h0000_0000, 32'h0000_0120, 32'h13579BDF);
    raddr2 = 5'd10;
    #1;
    chk("r10_readback", rdata2, 32'hFFFFFF80);

    // 4: write to r0 is a no-op; disabled write leaves r7 alone
    mem_rf_nwe = 1'b0; mem_rd = 5'd0; mem_rf_wsel = 3'd0; mem_alu_out = 32'h1234; raddr1 = 5'd0;
    #1;
    chk("r0_bypass", rdata1, 32'd0);
    tick();
    chk("r0_we", {31'd0, wb_we}, 32'd0);
    chk("r0_count", {24'd0, wb_count}, {24'd0, exp_count});
    chk("r0_waddr_hold", {27'd0, wb_waddr}, 32'd15);
    chk("r0_read", rdata1, 32'd0);
    mem_rf_nwe = 1'b1; mem_rd = 5'd7; raddr1 = 5'd7;
    #1;
    chk("nwe1_nobypass", rdata1, 32'd0);
    tick();
    chk("nwe1_r7", rdata1, 32'd0);
    chk("nwe1_we", {31'd0, wb_we}, 32'd0);
    chk("nwe1_wdata_hold", wb_wdata, 32'h13579BDF);

    // 5: link
    do_write("link_r31", 5'd31, 3'd2, 32'h0000_0000, 32'h00400010, 32'h00400014);

    // 6: reset wins over a write, bypass disabled during reset
    reset = 1'b1; mem_rf_nwe = 1'b0; mem_rd = 5'd9; mem_rf_wsel = 3'd0;
    mem_alu_out = 32'hCAFEF00D; raddr1 = 5'd9; raddr2 = 5'd5;
    #1;
    chk("rst_bypass_off", rdata1, 32'd0);
    chk("rst_read_r5", rdata2, 32'd0);
    tick();
    reset = 1'b0; mem_rf_nwe = 1'b1;
    exp_count = '0;
    #1;
    chk("rst_r9", rdata1, 32'd0);
    chk("rst_r5", rdata2, 32'd0);
    chk("rst_count", {24'd0, wb_count}, 32'd0);
    chk("rst_we", {31'd0, wb_we}, 32'd0);
    chk("rst_waddr", {27'd0, wb_waddr}, 32'd0);
    chk("rst_pc", wb_pc, 32'd0);

    // counter wrap: 2^CNT_W-1 writes, then one more
    mem_rf_nwe = 1'b0; mem_rd = 5'd1; mem_rf_wsel = 3'd0;
    for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
      mem_alu_out = 32'(i);
      tick();
    end
    mem_rf_nwe = 1'b1;
    exp_count = '1;
    #1;
    chk("cnt_max", {24'd0, wb_count}, 32'h0000_00FF);
    raddr1 = 5'd1;
    #1;
    chk("cnt_last_r1", rdata1, 32'd254);
    do_write("cnt_wrap", 5'd1, 3'd0, 32'hA5A5_0001, 32'h0000_0200, 32'hA5A5_0001);
    chk("cnt_zero", {24'd0, wb_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
